// File: rtl/spi_flash_id_responder_pkg.sv
// Shared definitions for the SPI flash ID responder: opcodes, address
// width and FSM state encoding.
package spi_flash_pkg;

  localparam logic [7:0] OP_MFR_DEV_ID = 8'h90;
  localparam logic [7:0] OP_JEDEC_ID   = 8'h9F;
  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;
  localparam logic [7:0] OP_READ_SR1   = 8'h05;

  localparam int ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

endpackage

// File: rtl/spi_flash_id_responder_if.sv
// SPI pin bundle between a flash master and the ID responder.
// Handshake: there is no valid/ready pair on this bus; a transfer is framed
// by spi_cs_n low, the master samples spi_do on rising spi_clk and the slave
// changes spi_do after falling spi_clk, only while spi_do_oe is high.
interface spi_flash_id_responder_if;
  logic spi_cs_n;
  logic spi_clk;
  logic spi_di;
  logic spi_do;
  logic spi_do_oe;

  modport master (output spi_cs_n, output spi_clk, output spi_di,
                  input  spi_do,   input  spi_do_oe);
  modport slave  (input  spi_cs_n, input  spi_clk, input  spi_di,
                  output spi_do,   output spi_do_oe);
endinterface

// File: rtl/spi_flash_id_responder_edge_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized
// level. STAGES must be at least 2.
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Shift the asynchronous input through the chain and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;
  assign fall = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_flash_id_responder.sv
// SPI mode-0 slave emulating the ID-read commands of a W25X16-class flash.
// All SPI pins are oversampled in the sys_clk domain.
// Optional: define SPI_RESP_STATUS_EN to answer opcode 0x05 with STATUS_VAL.
module spi_flash_id_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] MFR_ID      = 8'hEF,
  parameter logic [7:0] DEV_ID      = 8'h14,
  parameter logic [7:0] JEDEC_TYPE  = 8'h30,
  parameter logic [7:0] JEDEC_CAP   = 8'h15,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] STATUS_VAL  = 8'h00
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  spi_flash_id_responder_if.slave  spi,
  output logic                     cmd_valid,
  output logic [7:0]               cmd_code,
  output logic                     busy,
  output state_t                   dbg_state
);

  logic cs_rise, cs_fall, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] di_sync_q;
  logic di_s;

  state_t     state_q, state_nxt;
  logic [4:0] bit_cnt_q, bit_cnt_nxt;
  logic [6:0] rx_q, rx_nxt;
  logic [7:0] cmd_code_q, cmd_code_nxt;
  logic       addr0_q, addr0_nxt;
  logic [1:0] byte_idx_q, byte_idx_nxt;
  logic [2:0] tx_cnt_q, tx_cnt_nxt;
  logic [6:0] tx_q, tx_nxt;
  logic       do_q, do_nxt;
  logic       oe_q, oe_nxt;
  logic       cmd_valid_q, cmd_valid_nxt;
  logic       busy_q, busy_nxt;
  logic [7:0] cur_byte;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(sys_clk), .rst(sys_rst), .din(spi.spi_cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(sys_clk), .rst(sys_rst), .din(spi.spi_clk), .rise(sck_rise), .fall(sck_fall)
  );

  // Same depth as the SCK chain so data stays aligned with the detected edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) di_sync_q <= '0;
    else         di_sync_q <= {di_sync_q[SYNC_STAGES-2:0], spi.spi_di};
  end
  assign di_s = di_sync_q[SYNC_STAGES-1];

  // Index of the final byte in each opcode's repeating response.
  function automatic logic [1:0] seq_last(input logic [7:0] op);
    case (op)
      OP_MFR_DEV_ID: seq_last = 2'd1;
      OP_JEDEC_ID:   seq_last = 2'd2;
      default:       seq_last = 2'd0;
    endcase
  endfunction

  // Response byte for a given opcode, address bit 0 and position.
  function automatic logic [7:0] seq_byte(input logic [7:0] op, input logic a0,
                                          input logic [1:0] idx);
    case (op)
      OP_MFR_DEV_ID: seq_byte = (idx[0] ^ a0) ? DEV_ID : MFR_ID;
      OP_JEDEC_ID: begin
        case (idx)
          2'd0:    seq_byte = MFR_ID;
          2'd1:    seq_byte = JEDEC_TYPE;
          default: seq_byte = JEDEC_CAP;
        endcase
      end
      OP_RELEASE_PD: seq_byte = DEV_ID;
      OP_READ_SR1:   seq_byte = STATUS_VAL;
      default:       seq_byte = 8'h00;
    endcase
  endfunction

  assign cur_byte = seq_byte(cmd_code_q, addr0_q, byte_idx_q);

  // State and datapath register bank.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      cmd_code_q  <= '0;
      addr0_q     <= 1'b0;
      byte_idx_q  <= '0;
      tx_cnt_q    <= '0;
      tx_q        <= '0;
      do_q        <= 1'b0;
      oe_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      bit_cnt_q   <= bit_cnt_nxt;
      rx_q        <= rx_nxt;
      cmd_code_q  <= cmd_code_nxt;
      addr0_q     <= addr0_nxt;
      byte_idx_q  <= byte_idx_nxt;
      tx_cnt_q    <= tx_cnt_nxt;
      tx_q        <= tx_nxt;
      do_q        <= do_nxt;
      oe_q        <= oe_nxt;
      cmd_valid_q <= cmd_valid_nxt;
      busy_q      <= busy_nxt;
    end
  end

  // Next-state and output logic; chip-select release overrides any SCK edge.
  always_comb begin
    state_nxt     = state_q;
    bit_cnt_nxt   = bit_cnt_q;
    rx_nxt        = rx_q;
    cmd_code_nxt  = cmd_code_q;
    addr0_nxt     = addr0_q;
    byte_idx_nxt  = byte_idx_q;
    tx_cnt_nxt    = tx_cnt_q;
    tx_nxt        = tx_q;
    do_nxt        = do_q;
    oe_nxt        = oe_q;
    cmd_valid_nxt = 1'b0;
    busy_nxt      = busy_q;

    if (cs_rise) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
      do_nxt    = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_nxt    = ST_CMD;
            bit_cnt_nxt  = '0;
            rx_nxt       = '0;
            byte_idx_nxt = '0;
            tx_cnt_nxt   = '0;
            busy_nxt     = 1'b1;
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_nxt      = {rx_q[5:0], di_s};
            bit_cnt_nxt = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              cmd_code_nxt  = {rx_q, di_s};
              cmd_valid_nxt = 1'b1;
              bit_cnt_nxt   = '0;
              case ({rx_q, di_s})
                OP_MFR_DEV_ID, OP_RELEASE_PD: state_nxt = ST_ADDR;
                OP_JEDEC_ID: begin
                  state_nxt = ST_DATA;
                  oe_nxt    = 1'b1;
                end
`ifdef SPI_RESP_STATUS_EN
                OP_READ_SR1: begin
                  state_nxt = ST_DATA;
                  oe_nxt    = 1'b1;
                end
`endif
                default: state_nxt = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            bit_cnt_nxt = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
              addr0_nxt = (cmd_code_q == OP_MFR_DEV_ID) ? di_s : 1'b0;
              state_nxt = ST_DATA;
              oe_nxt    = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (sck_fall) begin
            tx_cnt_nxt = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd0) begin
              do_nxt       = cur_byte[7];
              tx_nxt       = cur_byte[6:0];
              byte_idx_nxt = (byte_idx_q == seq_last(cmd_code_q)) ? 2'd0 : byte_idx_q + 2'd1;
            end else begin
              do_nxt = tx_q[6];
              tx_nxt = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_IGNORE: oe_nxt = 1'b0;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  assign spi.spi_do    = do_q;
  assign spi.spi_do_oe = oe_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_code      = cmd_code_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/spi_flash_id_responder.md
Name: spi_flash_id_responder

Overview:
- SPI mode-0 slave that emulates the ID-read side of a W25X16-class serial flash.
- Receives opcode, address and dummy bytes from an SPI master and shifts back manufacturer, device and JEDEC ID bytes.
- Serves as the bench/board-side counterpart to the team's flash ID reader, so the reader can be exercised without a physical flash.
- Samples all SPI pins in the sys_clk domain; no SPI-clock-domain flops.

Parameters:
- MFR_ID, 8'hEF, manufacturer ID byte.
- DEV_ID, 8'h14, device ID byte returned by 0x90 and 0xAB.
- JEDEC_TYPE, 8'h30, memory-type byte returned by 0x9F.
- JEDEC_CAP, 8'h15, capacity byte returned by 0x9F.
- SYNC_STAGES, 2, synchronizer depth for spi_cs_n, spi_clk and spi_di (minimum 2).
- STATUS_VAL, 8'h00, status byte; used only when SPI_RESP_STATUS_EN is defined.

Ports:
- sys_clk  in  1  system clock, at least 8x the SPI clock rate.
- sys_rst  in  1  synchronous, active-high reset.
- spi_cs_n  in  1  chip select from the master, active low.
- spi_clk  in  1  SPI clock from the master, idles low.
- spi_di  in  1  master-to-slave data.
- spi_do  out  1  slave-to-master data.
- spi_do_oe  out  1  output enable for the spi_do pad, high while driving.
- cmd_valid  out  1  one-cycle pulse when an opcode byte completes.
- cmd_code  out  8  last received opcode, held until the next opcode.
- busy  out  1  high while chip select is asserted.

Behaviour:
- Reset: spi_do=0, spi_do_oe=0, cmd_valid=0, cmd_code=8'h00, busy=0, FSM=IDLE, all counters and shift registers 0.
- Synchronization: synchronize spi_cs_n, spi_clk and spi_di through SYNC_STAGES flops. Derive sck_rise, sck_fall, cs_fall and cs_rise from the last two stages.
- Sampling and driving: sample spi_di on sck_rise, MSB first. Update spi_do on sck_fall.
- Output latency: spi_do settles within SYNC_STAGES+2 sys_clk cycles after the physical SCK falling edge.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: on cs_fall, go to CMD, clear the bit counter, set busy=1.
- CMD: after the 8th sck_rise, latch cmd_code and pulse cmd_valid for one cycle, then decode:
  - 0x90 or 0xAB: go to ADDR (24 bits).
  - 0x9F: go to DATA with byte index 0.
  - Any other opcode: go to IGNORE.
- ADDR: after the 24th sck_rise, record addr bit0 (0x90 only) and go to DATA.
- DATA:
  - On entering DATA, spi_do_oe=1. The MSB of the first byte is presented on the first sck_fall after the final command or address bit.
  - 0x90 with addr bit0=0: bytes MFR_ID, DEV_ID, repeating.
  - 0x90 with addr bit0=1: bytes DEV_ID, MFR_ID, repeating.
  - 0x9F: bytes MFR_ID, JEDEC_TYPE, JEDEC_CAP, then repeats from MFR_ID.
  - 0xAB: DEV_ID, repeating.
  - The byte index wraps modulo the sequence length. The bit counter is 3 bits and wraps 7->0 to load the next byte.
- IGNORE: spi_do_oe=0; ignore SCK edges until cs_rise.
- CS deassertion: cs_rise in any state returns to IDLE on the same cycle, spi_do_oe=0, busy=0, partial bytes discarded. cmd_code is retained.
- Simultaneous cs_rise and sck edge: cs_rise wins; the SCK edge is ignored.
- SCK edges while chip select is high are ignored.
- Mid-operation reset: sys_rst forces all reset values on the next clock regardless of SPI pin state. After reset, the responder waits for a fresh cs_fall; it does not join a transaction already in progress.

Optional Feature:
- Macro: SPI_RESP_STATUS_EN.
- Defined: opcode 0x05 (Read Status Register-1) goes directly to DATA and returns STATUS_VAL repeatedly until cs_rise.
- Undefined: 0x05 is treated as unknown and goes to IGNORE; cmd_valid still pulses with cmd_code=8'h05.

Decomposition:
- Package spi_flash_pkg holds:
  - opcode constants OP_MFR_DEV_ID=8'h90, OP_JEDEC_ID=8'h9F, OP_RELEASE_PD=8'hAB, OP_READ_SR1=8'h05;
  - the FSM state enum;
  - ADDR_BITS=24.
- Sub-module spi_edge_sync: parameterized synchronizer plus rise/fall edge detector, instantiated once each for spi_cs_n and spi_clk. spi_di uses the synchronizer only.

Test Plan:
- 0x90 with address 24'h000000, 32 read clocks -> spi_do bytes EF,14,EF,14; cmd_valid pulses once with cmd_code=8'h90.
- 0x90 with address 24'h000001, 16 read clocks -> bytes 14,EF.
- 0x9F, 32 read clocks -> bytes EF,30,15,EF; spi_do_oe=1 from the first data bit until cs_rise, then 0.
- 0xAB with 3 dummy bytes, 16 read clocks -> bytes 14,14.
- Opcode 0x03 -> spi_do_oe stays 0, cmd_code=8'h03. Then CS high after 12 address bits of a 0x90, followed by a full 0x90 transaction -> EF,14, proving recovery.
- sys_rst asserted for one cycle during the DATA phase -> all outputs at reset values the next cycle. Rerun with SPI_RESP_STATUS_EN defined and 0x05 -> STATUS_VAL repeated.
